// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for seq_divider.
// The master side drives operands and consumes results.
interface seq_divider_if #(
   parameter int unsigned WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic                 S;
   logic                 V;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   Y;
   logic [1:0]           dbz;

   modport master (
      output in_valid, A, B, S, V, out_ready,
      input  in_ready, out_valid, Y, dbz
   );

   modport slave (
      input  in_valid, A, B, S, V, out_ready,
      output in_ready, out_valid, Y, dbz
   );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider: scalar WIDTH-bit or two WIDTH/2-bit lanes,
// signed or unsigned, producing {R, Q} with truncation toward zero.
module seq_divider #(
   parameter int unsigned WIDTH = 8
) (
   input logic         clk,
   input logic         rst,
   seq_divider_if.slave bus
);
   localparam int unsigned H  = WIDTH / 2;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               v_q, v_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   div_q, div_d;
   logic [1:0]         qneg_q, qneg_d;
   logic [1:0]         rneg_q, rneg_d;
   logic [2*WIDTH-1:0] y_q, y_d;
   logic [1:0]         dbz_q, dbz_d;

   function automatic logic [H-1:0] cneg_h(input logic n, input logic [H-1:0] x);
      return n ? -x : x;
   endfunction

   function automatic logic [WIDTH-1:0] cneg_w(input logic n, input logic [WIDTH-1:0] x);
      return n ? -x : x;
   endfunction

   // Operand conditioning at acceptance
   logic               an_h, an_l, bn_h, bn_l;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [1:0]         qneg_in, rneg_in;

   always_comb begin
      an_h = bus.S & bus.A[WIDTH-1];
      an_l = bus.S & bus.A[H-1];
      bn_h = bus.S & bus.B[WIDTH-1];
      bn_l = bus.S & bus.B[H-1];
      if (bus.V) begin
         mag_a   = {cneg_h(an_h, bus.A[WIDTH-1:H]), cneg_h(an_l, bus.A[H-1:0])};
         mag_b   = {cneg_h(bn_h, bus.B[WIDTH-1:H]), cneg_h(bn_l, bus.B[H-1:0])};
         qneg_in = {an_h ^ bn_h, an_l ^ bn_l};
         rneg_in = {an_h, an_l};
      end else begin
         mag_a   = cneg_w(an_h, bus.A);
         mag_b   = cneg_w(bn_h, bus.B);
         qneg_in = {1'b0, an_h ^ bn_h};
         rneg_in = {1'b0, an_h};
      end
   end

   // One restoring step; a zero divisor always "succeeds", which leaves the
   // dividend in the remainder and all ones in the quotient.
   logic [WIDTH:0]     sh_s, diff_s;
   logic [H:0]         sh_h, diff_h, sh_l, diff_l;
   logic [WIDTH-1:0]   step_rem, step_quo;

   always_comb begin
      sh_s   = {rem_q, quo_q[WIDTH-1]};
      diff_s = sh_s - {1'b0, div_q};
      sh_h   = {rem_q[WIDTH-1:H], quo_q[WIDTH-1]};
      diff_h = sh_h - {1'b0, div_q[WIDTH-1:H]};
      sh_l   = {rem_q[H-1:0], quo_q[H-1]};
      diff_l = sh_l - {1'b0, div_q[H-1:0]};
      if (v_q) begin
         step_rem = {diff_h[H] ? sh_h[H-1:0] : diff_h[H-1:0],
                     diff_l[H] ? sh_l[H-1:0] : diff_l[H-1:0]};
         step_quo = {quo_q[WIDTH-2:H], ~diff_h[H], quo_q[H-2:0], ~diff_l[H]};
      end else begin
         step_rem = diff_s[WIDTH] ? sh_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
         step_quo = {quo_q[WIDTH-2:0], ~diff_s[WIDTH]};
      end
   end

   // Sign correction; divide-by-zero lanes bypass it
   logic [WIDTH-1:0]   qs, rs;
   logic [H-1:0]       qh, rh, ql, rl;
   logic [2*WIDTH-1:0] y_fix;
   logic [1:0]         dbz_fix;

   always_comb begin
      qs = cneg_w(qneg_q[0], quo_q);
      rs = cneg_w(rneg_q[0], rem_q);
      if (b_q == '0) begin
         qs = '1;
         rs = a_q;
      end
      qh = cneg_h(qneg_q[1], quo_q[WIDTH-1:H]);
      rh = cneg_h(rneg_q[1], rem_q[WIDTH-1:H]);
      if (b_q[WIDTH-1:H] == '0) begin
         qh = '1;
         rh = a_q[WIDTH-1:H];
      end
      ql = cneg_h(qneg_q[0], quo_q[H-1:0]);
      rl = cneg_h(rneg_q[0], rem_q[H-1:0]);
      if (b_q[H-1:0] == '0) begin
         ql = '1;
         rl = a_q[H-1:0];
      end
      if (v_q) begin
         y_fix   = {rh, rl, qh, ql};
         dbz_fix = {b_q[WIDTH-1:H] == '0, b_q[H-1:0] == '0};
      end else begin
         y_fix   = {rs, qs};
         dbz_fix = {1'b0, b_q == '0};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      v_d     = v_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      div_d   = div_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      y_d     = y_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         IDLE: if (bus.in_valid) begin
            state_d = BUSY;
            a_d     = bus.A;
            b_d     = bus.B;
            v_d     = bus.V;
            quo_d   = mag_a;
            div_d   = mag_b;
            rem_d   = '0;
            qneg_d  = qneg_in;
            rneg_d  = rneg_in;
            cnt_d   = bus.V ? CW'(H) : CW'(WIDTH);
         end
         // The trailing cnt==0 cycle pads BUSY so latency is N+2 edges.
         BUSY: if (cnt_q == '0) begin
            state_d = FIX;
         end else begin
            cnt_d = cnt_q - CW'(1);
            rem_d = step_rem;
            quo_d = step_quo;
         end
         FIX: begin
            y_d     = y_fix;
            dbz_d   = dbz_fix;
            state_d = DONE;
         end
         DONE: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         v_q     <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         div_q   <= '0;
         qneg_q  <= '0;
         rneg_q  <= '0;
         y_q     <= '0;
         dbz_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         v_q     <= v_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         y_q     <= y_d;
         dbz_q   <= dbz_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.Y         = y_q;
   assign bus.dbz       = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed vector bench for seq_divider (WIDTH=8): table of operations with
// hand-computed results plus backpressure and mid-operation reset sequences.
module tb_seq_divider;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   seq_divider_if #(.WIDTH(8)) bus ();

   seq_divider #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [7:0] a;
      logic [7:0] b;
      logic       s;
      logic       v;
      logic [15:0] y;
      logic [1:0] dbz;
      int         lat;
   } vec_t;

   vec_t vecs[13];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start(input logic [7:0] a, input logic [7:0] b, input logic s, input logic v);
      bus.A        = a;
      bus.B        = b;
      bus.S        = s;
      bus.V        = v;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.A        = 8'($urandom);
      bus.B        = 8'($urandom);
      bus.S        = 1'($urandom);
      bus.V        = 1'($urandom);
   endtask

   task automatic wait_valid(input string name, input int exp_lat);
      int cyc;
      cyc = 0;
      while (bus.out_valid !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
      check({name, " latency"}, cyc, exp_lat);
   endtask

   task automatic handshake(input string name);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({name, " out_valid drop"}, {31'd0, bus.out_valid}, 32'd0);
      check({name, " in_ready back"}, {31'd0, bus.in_ready}, 32'd1);
   endtask

   task automatic run_vec(input vec_t t);
      check({t.name, " in_ready idle"}, {31'd0, bus.in_ready}, 32'd1);
      start(t.a, t.b, t.s, t.v);
      wait_valid(t.name, t.lat);
      check({t.name, " Y"}, {16'd0, bus.Y}, {16'd0, t.y});
      check({t.name, " dbz"}, {30'd0, bus.dbz}, {30'd0, t.dbz});
      handshake(t.name);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      vecs[0]  = '{"u200div7",    8'hC8, 8'h07, 1'b0, 1'b0, 16'h041C, 2'b00, 10};
      vecs[1]  = '{"s-7div2",     8'hF9, 8'h02, 1'b1, 1'b0, 16'hFFFD, 2'b00, 10};
      vecs[2]  = '{"s_ovf",       8'h80, 8'hFF, 1'b1, 1'b0, 16'h0080, 2'b00, 10};
      vecs[3]  = '{"u_dbz",       8'h2A, 8'h00, 1'b0, 1'b0, 16'h2AFF, 2'b01, 10};
      vecs[4]  = '{"v_u",         8'hD7, 8'h42, 1'b0, 1'b1, 16'h1133, 2'b00, 6};
      vecs[5]  = '{"v_dbz_hi",    8'h95, 8'h03, 1'b0, 1'b1, 16'h92F1, 2'b10, 6};
      vecs[6]  = '{"s_dbz",       8'hF9, 8'h00, 1'b1, 1'b0, 16'hF9FF, 2'b01, 10};
      vecs[7]  = '{"u255div1",    8'hFF, 8'h01, 1'b0, 1'b0, 16'h00FF, 2'b00, 10};
      vecs[8]  = '{"s7div-7",     8'h07, 8'hF9, 1'b1, 1'b0, 16'h00FF, 2'b00, 10};
      vecs[9]  = '{"s7div-2",     8'h07, 8'hFE, 1'b1, 1'b0, 16'h01FD, 2'b00, 10};
      vecs[10] = '{"v_s_ovf",     8'h8F, 8'hF2, 1'b1, 1'b1, 16'h0F80, 2'b00, 6};
      vecs[11] = '{"v_s_dbz_lo",  8'h5B, 8'h20, 1'b1, 1'b1, 16'h1B2F, 2'b01, 6};
      vecs[12] = '{"u5div9",      8'h05, 8'h09, 1'b0, 1'b0, 16'h0500, 2'b00, 10};

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      bus.S         = 1'b0;
      bus.V         = 1'b0;
      rst           = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset Y", {16'd0, bus.Y}, 32'd0);
      check("reset dbz", {30'd0, bus.dbz}, 32'd0);

      for (int i = 0; i < 13; i++) run_vec(vecs[i]);

      // Backpressure: result held, new request ignored while in DONE
      start(8'hF9, 8'h02, 1'b1, 1'b0);
      wait_valid("bp", 10);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = (i == 2);
         bus.A        = 8'h11;
         bus.B        = 8'h01;
         check("bp Y hold", {16'd0, bus.Y}, 32'h0000FFFD);
         check("bp dbz hold", {30'd0, bus.dbz}, 32'd0);
         check("bp out_valid hold", {31'd0, bus.out_valid}, 32'd1);
         check("bp in_ready low", {31'd0, bus.in_ready}, 32'd0);
         tick();
      end
      bus.in_valid = 1'b0;
      handshake("bp");
      check("bp Y kept", {16'd0, bus.Y}, 32'h0000FFFD);
      run_vec(vecs[12]);

      // Reset during the third BUSY cycle
      start(8'hC8, 8'h07, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("midrst Y", {16'd0, bus.Y}, 32'd0);
      check("midrst dbz", {30'd0, bus.dbz}, 32'd0);
      check("midrst in_ready", {31'd0, bus.in_ready}, 32'd1);
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 15; i++) begin
            if (bus.out_valid === 1'b1) seen++;
            tick();
         end
         check("midrst no stale result", seen, 0);
      end
      run_vec(vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
